// File: rtl/pmod_pkg.sv
// Shared constants for the PMOD button driver: pin map, FSM encoding, LFSR seed
// and the command record latched at acceptance.
package pmod_pkg;
  localparam int BTN_LO  = 0;
  localparam int NUM_BTN = 3;
  localparam int LED_LO  = 3;
  localparam int NUM_LED = 5;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_BOUNCE_IN  = 3'd1;
  localparam logic [2:0] ST_HOLD       = 3'd2;
  localparam logic [2:0] ST_BOUNCE_OUT = 3'd3;
  localparam logic [2:0] ST_GAP        = 3'd4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic [1:0]  btn;
    logic [7:0]  hold;
    logic [15:0] seed;
  } cmd_t;
endpackage

// File: rtl/lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR (x^16+x^14+x^13+x^11+1), advances when i_en.
module lfsr16
  import pmod_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [15:0] o_state
);
  logic [15:0] r_state;
  logic        w_fb;

  assign w_fb = r_state[15] ^ r_state[13] ^ r_state[12] ^ r_state[10];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_state <= LFSR_SEED;
    else if (i_en) r_state <= {r_state[14:0], w_fb};
  end

  assign o_state = r_state;
endmodule

// File: rtl/pmod_btn_driver.sv
// Presses PMOD buttons (open-drain, active low) with simulated contact bounce,
// and synchronizes the LED pins back into led_val.
module pmod_btn_driver
  import pmod_pkg::*;
#(
  parameter int TICK_CYCLES  = 1000,
  parameter int BOUNCE_TICKS = 4,
  parameter int GAP_TICKS    = 8
)(
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] pmod,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_btn,
  input  logic [7:0] cmd_hold,
  output logic       busy,
  output logic       done,
  output logic [4:0] led_val,
  output logic       led_changed
);
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [7:0]    B_LAST    = 8'(BOUNCE_TICKS - 1);
  localparam logic [7:0]    G_LAST    = 8'(GAP_TICKS - 1);

  logic [2:0]    r_state;
  logic [TW-1:0] r_tick_cnt;
  logic [7:0]    r_cnt;
  cmd_t          r_cmd;
  logic          r_lvl;
  logic          r_done;
  logic          r_rdy;

  logic [15:0]        w_lfsr;
  logic               w_tick, w_accept, w_last, w_rand, w_press, w_next_lvl;
  logic [2:0]         w_next;
  logic [NUM_BTN-1:0] w_oe;

  assign w_tick   = (r_state != ST_IDLE) && (r_tick_cnt == TICK_LAST);
  assign w_accept = cmd_valid && cmd_ready;
  // Per-tick bounce bit mixes the running LFSR with the snapshot taken at acceptance.
  assign w_rand   = w_lfsr[0] ^ (^(w_lfsr & r_cmd.seed));

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_tick),
    .o_state (w_lfsr)
  );

  always_comb begin
    w_last = 1'b0;
    case (r_state)
      ST_BOUNCE_IN, ST_BOUNCE_OUT: w_last = (r_cnt == B_LAST);
      ST_HOLD:                     w_last = (r_cnt == r_cmd.hold - 8'd1);
      ST_GAP:                      w_last = (r_cnt == G_LAST);
      default:                     w_last = 1'b0;
    endcase
  end

  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_BOUNCE_IN:  w_next = ST_HOLD;
      ST_HOLD:       w_next = (BOUNCE_TICKS > 0) ? ST_BOUNCE_OUT :
                              (GAP_TICKS > 0) ? ST_GAP : ST_IDLE;
      ST_BOUNCE_OUT: w_next = (GAP_TICKS > 0) ? ST_GAP : ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  // A one-tick release bounce must already sit at the released level.
  assign w_next_lvl = (w_next == ST_BOUNCE_OUT) && (BOUNCE_TICKS != 1) && w_rand;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_cnt      <= '0;
      r_cmd      <= '0;
      r_lvl      <= 1'b0;
      r_done     <= 1'b0;
      r_rdy      <= 1'b0;
    end else begin
      r_rdy  <= 1'b1;
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_tick_cnt <= '0;
        r_cnt      <= '0;
        if (w_accept) begin
          r_cmd.btn  <= cmd_btn;
          r_cmd.hold <= (cmd_hold == 8'd0) ? 8'd1 : cmd_hold;
          r_cmd.seed <= w_lfsr;
          if (cmd_btn == 2'd3) begin
            r_done <= 1'b1;
          end else if (BOUNCE_TICKS == 0) begin
            r_state <= ST_HOLD;
          end else begin
            r_state <= ST_BOUNCE_IN;
            r_lvl   <= (BOUNCE_TICKS == 1) || w_lfsr[0];
          end
        end
      end else begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        if (w_tick) begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= w_next;
            r_lvl   <= w_next_lvl;
            r_done  <= (w_next == ST_IDLE);
          end else begin
            r_cnt <= r_cnt + 8'd1;
            // The final bounce tick settles at the level of the state that follows.
            if (r_cnt + 8'd1 == B_LAST) r_lvl <= (r_state == ST_BOUNCE_IN);
            else                        r_lvl <= w_rand;
          end
        end
      end
    end
  end

  assign w_press = (r_state == ST_HOLD) ||
                   (((r_state == ST_BOUNCE_IN) || (r_state == ST_BOUNCE_OUT)) && r_lvl);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    assign w_oe[g] = w_press && (r_cmd.btn == 2'(g));
    assign pmod[BTN_LO + g] = w_oe[g] ? 1'b0 : 1'bz;
  end

  assign cmd_ready = r_rdy && (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;

  logic [NUM_LED-1:0] r_sync1, r_sync2;
  logic [1:0]         r_fill;
  logic               r_chg;

  // r_fill masks the change pulse while the synchronizer first fills after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_fill  <= '0;
      r_chg   <= 1'b0;
    end else begin
      r_sync1 <= pmod[LED_LO +: NUM_LED];
      r_sync2 <= r_sync1;
      if (r_fill != 2'd2) r_fill <= r_fill + 2'd1;
      r_chg <= (r_fill == 2'd2) && (r_sync1 != r_sync2);
    end
  end

  assign led_val     = r_sync2;
  assign led_changed = r_chg;
endmodule

// File: tb/tb_pmod_btn_driver.sv
// Bench for pmod_btn_driver: a no-bounce and a bounce instance, done-cycle scoreboards.
module tb_pmod_btn_driver;
  logic       clk, rst;
  logic [4:0] led;
  logic       cv0, rdy0, busy0, done0, lc0;
  logic [1:0] cb0;
  logic [7:0] ch0;
  logic [4:0] lv0;
  logic       cv1, rdy1, busy1, done1, lc1;
  logic [1:0] cb1;
  logic [7:0] ch1;
  logic [4:0] lv1;
  wire  [7:0] p0, p1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q0[$];
  int exp_q1[$];
  int exp_d;
  logic [2:0] tr_pin [30];
  logic       tr_busy[30];
  logic       tr_rdy [30];

  assign p0[7:3] = led;
  assign p1[7:3] = led;
  for (genvar g = 0; g < 3; g++) begin : g_pu
    pullup (p0[g]);
    pullup (p1[g]);
  end

  pmod_btn_driver #(.TICK_CYCLES(4), .BOUNCE_TICKS(0), .GAP_TICKS(2)) dut0 (
    .clk(clk), .rst(rst), .pmod(p0), .cmd_valid(cv0), .cmd_ready(rdy0), .cmd_btn(cb0),
    .cmd_hold(ch0), .busy(busy0), .done(done0), .led_val(lv0), .led_changed(lc0));

  pmod_btn_driver #(.TICK_CYCLES(4), .BOUNCE_TICKS(4), .GAP_TICKS(2)) dut1 (
    .clk(clk), .rst(rst), .pmod(p1), .cmd_valid(cv1), .cmd_ready(rdy1), .cmd_btn(cb1),
    .cmd_hold(ch1), .busy(busy1), .done(done1), .led_val(lv1), .led_changed(lc1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  // Scoreboards: each done pulse must match the oldest expected completion cycle.
  always @(negedge clk) begin
    if (done0) begin
      checks++;
      if (exp_q0.size() == 0) begin
        errors++; $display("FAIL done0_unexpected cycle %0d exp none", cyc);
      end else begin
        exp_d = exp_q0.pop_front();
        if (cyc != exp_d) begin errors++; $display("FAIL done0_cycle got %0d exp %0d", cyc, exp_d); end
      end
    end
    if (done1) begin
      checks++;
      if (exp_q1.size() == 0) begin
        errors++; $display("FAIL done1_unexpected cycle %0d exp none", cyc);
      end else begin
        exp_d = exp_q1.pop_front();
        if (cyc != exp_d) begin errors++; $display("FAIL done1_cycle got %0d exp %0d", cyc, exp_d); end
      end
    end
  end

  task automatic accept0(input logic [1:0] b, input logic [7:0] h, output int n);
    @(negedge clk);
    cv0 = 1'b1; cb0 = b; ch0 = h;
    for (int k = 0; k < 100 && !rdy0; k++) @(negedge clk);
    n = cyc;
    @(posedge clk); #1;
    cv0 = 1'b0;
  endtask

  task automatic accept1(input logic [1:0] b, input logic [7:0] h, output int n);
    @(negedge clk);
    cv1 = 1'b1; cb1 = b; ch1 = h;
    for (int k = 0; k < 100 && !rdy1; k++) @(negedge clk);
    n = cyc;
    @(posedge clk); #1;
    cv1 = 1'b0;
  endtask

  task automatic trace0(input logic [1:0] b, input logic [7:0] h, input int done_off);
    int n;
    accept0(b, h, n);
    exp_q0.push_back(n + done_off);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      tr_pin[i] = p0[2:0]; tr_busy[i] = busy0; tr_rdy[i] = rdy0;
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; led = 5'b00011;
    cv0 = 0; cb0 = 0; ch0 = 0; cv1 = 0; cb1 = 0; ch1 = 0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({p0[2:0], p1[2:0]} !== 6'b111111) begin errors++; $display("FAIL rst_pins got %b exp 111111", {p0[2:0], p1[2:0]}); end
    checks++; if ({rdy0, busy0, done0, lc0, rdy1, busy1, done1, lc1} !== 8'h00) begin errors++; $display("FAIL rst_ctrl got %b exp 00000000", {rdy0, busy0, done0, lc0, rdy1, busy1, done1, lc1}); end
    checks++; if ({lv0, lv1} !== 10'd0) begin errors++; $display("FAIL rst_led got %b exp 0", {lv0, lv1}); end
    rst = 1'b1;
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL rdy_before_edge got %b exp 0", rdy0); end
    @(posedge clk); #1;
    checks++; if ({rdy0, rdy1} !== 2'b11) begin errors++; $display("FAIL rdy_first_edge got %b exp 11", {rdy0, rdy1}); end
    bad = 0;
    repeat (6) begin @(negedge clk); if (lc0 || lc1) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL led_fill_pulse got %0d exp 0", bad); end
    checks++; if (lv0 !== 5'b00011) begin errors++; $display("FAIL led_fill_val got %b exp 00011", lv0); end
  endtask

  task automatic test_led();
    int c, pulses;
    logic [4:0] e;
    @(negedge clk); led = 5'b00000;
    repeat (5) @(negedge clk);
    led = 5'b10101; c = cyc; pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = (cyc >= c + 2) ? 5'b10101 : 5'b00000;
      checks++; if (lv0 !== e || lv1 !== e) begin errors++; $display("FAIL led_val c+%0d got %b/%b exp %b", cyc - c, lv0, lv1, e); end
      checks++; if (lc0 !== (cyc == c + 2)) begin errors++; $display("FAIL led_changed c+%0d got %b exp %b", cyc - c, lc0, cyc == c + 2); end
      if (lc0) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL led_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_hold_nobounce();
    logic [2:0] e;
    trace0(2'd1, 8'd3, 1 + (3 + 2) * 4);
    for (int i = 0; i < 30; i++) begin
      e = (i < 12) ? 3'b101 : 3'b111;
      checks++; if (tr_pin[i] !== e) begin errors++; $display("FAIL hold_pins N+%0d got %b exp %b", i + 1, tr_pin[i], e); end
      checks++; if (tr_busy[i] !== (i < 20)) begin errors++; $display("FAIL hold_busy N+%0d got %b exp %b", i + 1, tr_busy[i], i < 20); end
    end
  endtask

  task automatic test_hold_zero();
    logic [2:0] first[30];
    trace0(2'd2, 8'd0, 1 + (1 + 2) * 4);
    for (int i = 0; i < 30; i++) first[i] = tr_pin[i];
    trace0(2'd2, 8'd1, 1 + (1 + 2) * 4);
    for (int i = 0; i < 30; i++) begin
      checks++; if (first[i] !== ((i < 4) ? 3'b011 : 3'b111)) begin errors++; $display("FAIL hold0_pins N+%0d got %b exp %b", i + 1, first[i], (i < 4) ? 3'b011 : 3'b111); end
      checks++; if (tr_pin[i] !== first[i]) begin errors++; $display("FAIL hold0_vs_hold1 N+%0d got %b exp %b", i + 1, tr_pin[i], first[i]); end
    end
  endtask

  task automatic test_noop();
    int bad;
    trace0(2'd3, 8'd7, 1);
    bad = 0;
    for (int i = 0; i < 30; i++) if (tr_pin[i] !== 3'b111 || tr_busy[i] !== 1'b0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL noop_activity got %0d exp 0", bad); end
    checks++; if (tr_rdy[0] !== 1'b1) begin errors++; $display("FAIL noop_ready got %b exp 1", tr_rdy[0]); end
  endtask

  task automatic test_back_to_back();
    int n, n2;
    logic [2:0] e;
    accept0(2'd0, 8'd2, n);
    exp_q0.push_back(n + 1 + (2 + 2) * 4);
    cv0 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      cb0 = 2'($urandom_range(0, 3)); ch0 = 8'($urandom);
      e = (i <= 8) ? 3'b110 : 3'b111;
      checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy N+%0d got %b exp 0", i, rdy0); end
      checks++; if (p0[2:0] !== e) begin errors++; $display("FAIL b2b_pins N+%0d got %b exp %b", i, p0[2:0], e); end
    end
    @(negedge clk);
    cb0 = 2'd2; ch0 = 8'd1; n2 = cyc;
    checks++; if (rdy0 !== 1'b1 || n2 != n + 17) begin errors++; $display("FAIL b2b_ready_done got %b@%0d exp 1@%0d", rdy0, n2 - n, 17); end
    exp_q0.push_back(n2 + 1 + (1 + 2) * 4);
    @(posedge clk); #1; cv0 = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      e = (i <= 4) ? 3'b011 : 3'b111;
      checks++; if (p0[2:0] !== e) begin errors++; $display("FAIL b2b_second N+%0d got %b exp %b", i, p0[2:0], e); end
    end
  endtask

  task automatic test_bounce();
    logic pin[53];
    logic bsy[53];
    int n, other, off, bad_in, bad_out, bcnt, total;
    logic [7:0] h;
    for (int r = 0; r < 2; r++) begin
      h = (r == 0) ? 8'd2 : 8'd1;
      total = (8 + int'(h) + 2) * 4;
      accept1(2'd0, h, n);
      exp_q1.push_back(n + 1 + total);
      pin[0] = 1'b1; bsy[0] = 1'b0; other = 0;
      for (int i = 1; i <= 52; i++) begin
        @(negedge clk);
        pin[i] = p1[0]; bsy[i] = busy1;
        if (p1[2:1] !== 2'b11) other++;
      end
      off = 0; bad_in = 0; bad_out = 0; bcnt = 0;
      for (int i = 1; i <= 52; i++) begin
        if ((i - 1) % 4 != 0 && pin[i] !== pin[i-1]) off++;
        if (i >= 13 && i <= 16 + 4 * int'(h) && pin[i] !== 1'b0) bad_in++;
        if (i >= 29 + 4 * int'(h) && pin[i] !== 1'b1) bad_out++;
        if (bsy[i]) bcnt++;
      end
      checks++; if (other != 0) begin errors++; $display("FAIL bounce_other_pins got %0d exp 0", other); end
      checks++; if (off != 0) begin errors++; $display("FAIL bounce_off_tick_toggle got %0d exp 0", off); end
      checks++; if (bad_in != 0) begin errors++; $display("FAIL bounce_in_last_tick got %0d exp 0", bad_in); end
      checks++; if (bad_out != 0) begin errors++; $display("FAIL bounce_out_last_tick got %0d exp 0", bad_out); end
      checks++; if (bcnt != total || bsy[1] !== 1'b1) begin errors++; $display("FAIL bounce_busy_time got %0d exp %0d", bcnt, total); end
    end
  endtask

  task automatic test_reset_mid_hold();
    int n, bad;
    accept0(2'd1, 8'd5, n);
    repeat (6) @(negedge clk);
    checks++; if (p0[1] !== 1'b0) begin errors++; $display("FAIL midhold_pressed got %b exp 0", p0[1]); end
    #2 rst = 1'b0;
    #1;
    checks++; if (p0[2:0] !== 3'b111) begin errors++; $display("FAIL midhold_async_release got %b exp 111", p0[2:0]); end
    checks++; if ({busy0, rdy0} !== 2'b00) begin errors++; $display("FAIL midhold_rst_ctrl got %b exp 00", {busy0, rdy0}); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL midhold_ready got %b exp 1", rdy0); end
    bad = 0;
    repeat (30) begin @(negedge clk); if (p0[2:0] !== 3'b111 || busy0 || lc0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL midhold_after got %0d exp 0", bad); end
  endtask

  initial begin
    test_reset();
    test_led();
    test_hold_nobounce();
    test_hold_zero();
    test_noop();
    test_back_to_back();
    test_bounce();
    test_reset_mid_hold();
    repeat (4) @(negedge clk);
    checks++; if (exp_q0.size() != 0 || exp_q1.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d/%0d exp 0/0", exp_q0.size(), exp_q1.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pmod_btn_driver.md
PMOD_BTN_DRIVER -- requirements
Module: pmod_btn_driver

Interface
REQ-001 Parameter TICK_CYCLES, default 1000: clk cycles per timing tick; legal range 1 or more.
REQ-002 Parameter BOUNCE_TICKS, default 4: ticks of simulated bounce on press and on release; 0 disables bounce.
REQ-003 Parameter GAP_TICKS, default 8: released ticks after each press before the next command is accepted.
REQ-004 Port clk, input, 1: single clock; all logic on posedge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port pmod, inout, 8: pmod[2:0] are active-low button pins, open-drain driven by this block; pmod[7:3] are LED pins, input only.
REQ-007 Port cmd_valid, input, 1: press command offered.
REQ-008 Port cmd_ready, output, 1: block accepts a command this cycle.
REQ-009 Port cmd_btn, input, 2: button index 0..2; value 3 is a no-op.
REQ-010 Port cmd_hold, input, 8: ticks the button is held steady; 0 is treated as 1.
REQ-011 Port busy, output, 1: high whenever the FSM is not IDLE.
REQ-012 Port done, output, 1: one-cycle pulse when a command completes.
REQ-013 Port led_val, output, 5: synchronized copy of pmod[7:3].
REQ-014 Port led_changed, output, 1: one-cycle pulse when led_val changes.

Function
REQ-015 Button pins SHALL only be driven low (oe=1, do=0) or released (oe=0); the block SHALL never drive a button pin high.
REQ-016 A command is accepted in cycle N when cmd_valid and cmd_ready are both high; cmd_ready SHALL be high only in IDLE.
REQ-017 cmd_btn, cmd_hold and an LFSR seed snapshot SHALL be latched at acceptance; later input changes SHALL have no effect.
REQ-018 The tick prescaler SHALL restart at acceptance, so the first tick boundary falls TICK_CYCLES cycles after N+1.
REQ-019 FSM states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
REQ-020 Transitions: IDLE->BOUNCE_IN on accept (IDLE->HOLD if BOUNCE_TICKS=0); BOUNCE_IN->HOLD after BOUNCE_TICKS ticks; HOLD->BOUNCE_OUT after cmd_hold ticks (HOLD->GAP if BOUNCE_TICKS=0); BOUNCE_OUT->GAP after BOUNCE_TICKS ticks; GAP->IDLE after GAP_TICKS ticks.
REQ-021 In BOUNCE_IN and BOUNCE_OUT, the selected pin SHALL be pressed or released per tick according to one LFSR bit; the last bounce tick SHALL equal the following steady level (pressed for BOUNCE_IN, released for BOUNCE_OUT).
REQ-022 In HOLD the selected pin SHALL be pressed continuously; in GAP and IDLE all button pins SHALL be released.
REQ-023 The selected pin SHALL first change at cycle N+1.
REQ-024 done SHALL pulse in the cycle the FSM re-enters IDLE; cmd_ready SHALL rise in that same cycle.
REQ-025 cmd_btn=3 SHALL be accepted without any pin activity; done SHALL pulse at N+1 and busy SHALL stay low.
REQ-026 The tick counter SHALL saturate-free wrap at TICK_CYCLES-1; hold and bounce counters SHALL be 8 bits wide.
REQ-027 pmod[7:3] SHALL pass through a 2-flop synchronizer into led_val, giving 2 cycles of latency.
REQ-028 led_changed SHALL pulse for one cycle whenever the new led_val differs from the previous led_val, independent of FSM state.

Reset
REQ-029 While rst=0: all button pins released, FSM in IDLE, cmd_ready=0, busy=0, done=0, led_val=0, led_changed=0, all counters 0, LFSR set to a nonzero constant.
REQ-030 Reset asserted mid-press SHALL release the pins immediately (asynchronously); the command is lost.
REQ-031 cmd_ready SHALL rise on the first clk edge after rst deasserts; led_changed SHALL NOT pulse for the first synchronizer fill.

Structure
REQ-032 The FSM state encoding and the pin map constants (BTN_LO=0, LED_LO=3) SHALL reside in a shared package, pmod_pkg.
REQ-033 A single sub-module, lfsr16 (16-bit maximal-length LFSR with enable input), SHALL supply the bounce bits; it advances once per tick.

Verification
REQ-034 Scenario: TICK_CYCLES=4, BOUNCE_TICKS=0, GAP_TICKS=2, accept {btn=1, hold=3} at N -> pmod[1] pressed during N+1..N+12, released from N+13, done at N+21, other pins released throughout.
REQ-035 Scenario: BOUNCE_TICKS=4 -> pmod[x] toggles only on tick boundaries, is pressed in the 4th BOUNCE_IN tick and released in the 4th BOUNCE_OUT tick; total busy time = (8+hold+GAP_TICKS)*TICK_CYCLES.
REQ-036 Scenario: cmd_hold=0 -> behaves identically to cmd_hold=1; cmd_btn=3 -> no pin activity and done at N+1.
REQ-037 Scenario: cmd_valid held high with changing cmd_btn while busy -> cmd_ready=0 and the latched press is unaffected; the next command is accepted in the done cycle.
REQ-038 Scenario: drive pmod[7:3] from 00000 to 10101 -> led_val=10101 two cycles later, with exactly one led_changed pulse.
REQ-039 Scenario: assert rst during HOLD -> pin released with no clk edge; after release, cmd_ready=1 on the first edge and no done pulse is generated.
